// File: rtl/fifo_pkg.sv
// Shared FIFO pointer constants and Gray-code helpers, used by both the
// write-side and read-side pointer blocks.
package fifo_pkg;

    localparam int ADDR_SIZE_DEF = 4;
    localparam int AF_THRESH_DEF = 14;

    // Binary to reflected Gray code. Callers zero-extend narrower pointers
    // into 32 bits and truncate the result back; the low bits are unaffected.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Mask of the two Gray MSBs. A pointer exactly one lap (2^ADDR_SIZE)
    // ahead of another differs from it in precisely these two bits.
    function automatic logic [31:0] gray_full_mask(input int ptr_w);
        return 32'h3 << (ptr_w - 2);
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary decoder of configurable width.
module gray2bin #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    // Each binary bit is the XOR of all Gray bits at and above it.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign bin_o[gi] = ^gray_i[WIDTH-1:gi];
        end
    endgenerate

endmodule

// File: rtl/wptr_full_gen.sv
// Write-side pointer block of an asynchronous FIFO: binary/Gray write
// pointer, full and almost-full flags, occupancy estimate and sticky
// overflow. The read pointer arrives already synchronized into clk.
module wptr_full_gen
    import fifo_pkg::*;
#(
    parameter int ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int AF_THRESH = AF_THRESH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 winc,
    input  logic [ADDR_SIZE:0]   wq2_rptr,
    output logic                 wen,
    output logic [ADDR_SIZE-1:0] waddr,
    output logic [ADDR_SIZE:0]   wptr,
    output logic                 wfull,
    output logic                 walmost_full,
    output logic [ADDR_SIZE:0]   wlevel,
    output logic                 woverflow
);

    localparam int PW = ADDR_SIZE + 1;
    localparam logic [PW-1:0] FULL_MASK   = PW'(gray_full_mask(PW));
    localparam logic [PW-1:0] AF_THRESH_W = PW'(AF_THRESH);

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] wlevel_q, wlevel_d;
    logic          wfull_q, wfull_d;
    logic          walmost_full_q, walmost_full_d;
    logic          woverflow_q, woverflow_d;
    logic [PW-1:0] rbin;

    gray2bin #(
        .WIDTH (PW)
    ) u_rptr_dec (
        .gray_i (wq2_rptr),
        .bin_o  (rbin)
    );

    // A write is accepted only while not full; this gates the pointer too.
    assign wen = winc & ~wfull_q;

    // Next pointer, flags and level, all computed from the post-write
    // pointer and the current synchronized read pointer.
    always_comb begin
        wbin_d         = wbin_q + {{ADDR_SIZE{1'b0}}, wen};
        wptr_d         = PW'(bin2gray(32'(wbin_d)));
        wlevel_d       = wbin_d - rbin;
        wfull_d        = (wptr_d == (wq2_rptr ^ FULL_MASK));
        walmost_full_d = (wlevel_d >= AF_THRESH_W);
        woverflow_d    = woverflow_q | (winc & wfull_q);
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wbin_q         <= '0;
            wptr_q         <= '0;
            wlevel_q       <= '0;
            wfull_q        <= 1'b0;
            walmost_full_q <= 1'b0;
            woverflow_q    <= 1'b0;
        end else begin
            wbin_q         <= wbin_d;
            wptr_q         <= wptr_d;
            wlevel_q       <= wlevel_d;
            wfull_q        <= wfull_d;
            walmost_full_q <= walmost_full_d;
            woverflow_q    <= woverflow_d;
        end
    end

    assign waddr        = wbin_q[ADDR_SIZE-1:0];
    assign wptr         = wptr_q;
    assign wfull        = wfull_q;
    assign walmost_full = walmost_full_q;
    assign wlevel       = wlevel_q;
    assign woverflow    = woverflow_q;

endmodule

// File: tb/tb_wptr_full_gen.sv
// Self-checking bench for wptr_full_gen: directed fill/overflow/release/
// wrap/almost-full/reset scenarios followed by randomized traffic, all
// compared every cycle against an occupancy-count model.
module tb_wptr_full_gen;

    localparam int AS    = 4;
    localparam int PW    = AS + 1;
    localparam int DEPTH = 16;
    localparam int MOD   = 32;
    localparam int AF    = 14;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          winc = 1'b0;
    logic [PW-1:0] wq2_rptr = '0;
    logic          wen;
    logic [AS-1:0] waddr;
    logic [PW-1:0] wptr;
    logic          wfull;
    logic          walmost_full;
    logic [PW-1:0] wlevel;
    logic          woverflow;

    wptr_full_gen #(
        .ADDR_SIZE (AS),
        .AF_THRESH (AF)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .winc         (winc),
        .wq2_rptr     (wq2_rptr),
        .wen          (wen),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wlevel       (wlevel),
        .woverflow    (woverflow)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Model: writes counted mod 32, reads given as a binary count.
    int m_wbin  = 0;
    int m_level = 0;
    int rd      = 0;
    bit m_full  = 0;
    bit m_af    = 0;
    bit m_ovf   = 0;

    function automatic logic [PW-1:0] to_gray(input int v);
        logic [PW-1:0] b;
        b = PW'(v);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic check_all();
        chk("waddr", 32'(waddr), 32'(m_wbin % DEPTH));
        chk("wptr", 32'(wptr), 32'(to_gray(m_wbin)));
        chk("wfull", 32'(wfull), 32'(m_full));
        chk("walmost_full", 32'(walmost_full), 32'(m_af));
        chk("wlevel", 32'(wlevel), 32'(m_level));
        chk("woverflow", 32'(woverflow), 32'(m_ovf));
    endtask

    // One cycle: drive inputs, check wen, clock, advance model, check outputs.
    task automatic step(input bit w, input int rd_new, input bit rn);
        int e;
        winc     = w;
        rd       = rd_new % MOD;
        wq2_rptr = to_gray(rd);
        rst_n    = rn;
        #1;
        chk("wen", 32'(wen), 32'(w && !m_full));
        @(posedge clk);
        if (!rn) begin
            m_wbin = 0; m_level = 0; m_full = 0; m_af = 0; m_ovf = 0;
        end else begin
            e = (w && !m_full) ? 1 : 0;
            if (w && m_full) m_ovf = 1;
            m_wbin  = (m_wbin + e) % MOD;
            m_level = (m_wbin - rd + MOD) % MOD;
            m_full  = (m_level == DEPTH);
            m_af    = (m_level >= AF);
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int hist [$];
        int full_seen;
        bit w;
        bit rn;
        int r;

        @(negedge clk);
        // Reset state
        step(0, 0, 0);
        step(0, 0, 0);
        chk("reset_wptr", 32'(wptr), 32'd0);

        // Fill: 16 writes, read pointer parked at 0
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 1);
            if (i == 2) chk("fill_wptr3", 32'(wptr), 32'b00010);
        end
        chk("fill_wptr", 32'(wptr), 32'b11000);
        chk("fill_wfull", 32'(wfull), 32'd1);
        chk("fill_wlevel", 32'(wlevel), 32'd16);
        chk("fill_af", 32'(walmost_full), 32'd1);

        // Overflow: writes while full are dropped, error sticks
        for (int i = 0; i < 3; i++) step(1, 0, 1);
        chk("ovf_wptr", 32'(wptr), 32'b11000);
        chk("ovf_flag", 32'(woverflow), 32'd1);

        // Release: one read frees a slot
        step(0, 1, 1);
        chk("rel_wfull", 32'(wfull), 32'd0);
        chk("rel_wlevel", 32'(wlevel), 32'd15);
        chk("rel_af", 32'(walmost_full), 32'd1);
        chk("rel_ovf", 32'(woverflow), 32'd1);

        // Wrap: 32 writes, read pointer trailing two cycles behind
        step(0, 0, 0);
        full_seen = 0;
        hist.delete();
        hist.push_back(0);
        hist.push_back(0);
        for (int i = 0; i < 32; i++) begin
            step(1, hist[hist.size() - 2], 1);
            hist.push_back(m_wbin);
            if (wfull) full_seen++;
        end
        chk("wrap_wptr", 32'(wptr), 32'd0);
        chk("wrap_waddr", 32'(waddr), 32'd0);
        chk("wrap_never_full", 32'(full_seen), 32'd0);

        // Almost-full edge at 13 -> 14 -> 13
        step(0, 0, 0);
        for (int i = 0; i < 13; i++) step(1, 0, 1);
        chk("af13_level", 32'(wlevel), 32'd13);
        chk("af13_flag", 32'(walmost_full), 32'd0);
        step(1, 0, 1);
        chk("af14_level", 32'(wlevel), 32'd14);
        chk("af14_flag", 32'(walmost_full), 32'd1);
        step(0, 1, 1);
        chk("af_back_level", 32'(wlevel), 32'd13);
        chk("af_back_flag", 32'(walmost_full), 32'd0);

        // Reset mid-fill with a write pending
        step(0, 0, 0);
        for (int i = 0; i < 9; i++) step(1, 0, 1);
        chk("mid_level", 32'(wlevel), 32'd9);
        step(1, 0, 0);
        chk("mid_rst_wptr", 32'(wptr), 32'd0);
        chk("mid_rst_level", 32'(wlevel), 32'd0);
        chk("mid_rst_ovf", 32'(woverflow), 32'd0);

        // Randomized traffic
        rd = 0;
        for (int i = 0; i < 600; i++) begin
            w  = ($urandom_range(0, 3) != 0);
            rn = ($urandom_range(0, 99) != 0);
            r  = rd;
            if ($urandom_range(0, 2) == 0 && ((m_wbin - r + MOD) % MOD) > 0)
                r = (r + 1) % MOD;
            if (!rn) r = 0;
            step(w, r, rn);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
